// File: rtl/rr_write_arbiter.sv
// Round-robin arbiter: four requesters share one register, each owner can hold it
// for at most MAX_HOLD cycles while others wait; write lands one edge after grant.
module rr_write_arbiter #(
  parameter int W        = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [3:0]     req,
  input  logic [4*W-1:0] data,
  output logic [3:0]     gnt,
  output logic [W-1:0]   q,
  output logic [1:0]     q_src,
  output logic           q_upd
);

  localparam int HW = $clog2(MAX_HOLD + 1);

  logic          owner_vld, owner_vld_nxt;
  logic [1:0]    owner, owner_nxt;
  logic [1:0]    last_ptr, last_nxt;
  logic [HW-1:0] hold, hold_nxt;

  logic [1:0]    base;
  logic [1:0]    pick;
  logic [1:0]    idx;
  logic          pick_vld;
  logic          owner_req;
  logic          hold_max;
  logic [3:0]    others;
  logic [W-1:0]  wr_dat;

  always_comb gnt = owner_vld ? (4'b0001 << owner) : 4'b0000;

  assign owner_req = owner_vld && req[owner];
  assign hold_max  = (hold == HW'(MAX_HOLD));
  assign others    = req & ~gnt;
  assign base      = owner_vld ? owner : last_ptr;
  assign wr_dat    = data[int'(owner)*W +: W];

  // Search from farthest to nearest so the nearest requester after base wins.
  always_comb begin
    pick_vld = 1'b0;
    pick     = 2'd0;
    idx      = 2'd0;
    for (int k = 4; k >= 1; k--) begin
      idx = base + 2'(k);
      if (req[idx]) begin
        pick     = idx;
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    owner_vld_nxt = owner_vld;
    owner_nxt     = owner;
    last_nxt      = last_ptr;
    hold_nxt      = hold;
    if (owner_req && (!hold_max || others == 4'b0000)) begin
      if (!hold_max) hold_nxt = hold + 1'b1;
    end else if (pick_vld) begin
      // Covers rotation on expiry, hand-off on release and grant from idle.
      owner_vld_nxt = 1'b1;
      owner_nxt     = pick;
      last_nxt      = pick;
      hold_nxt      = HW'(1);
    end else begin
      owner_vld_nxt = 1'b0;
      hold_nxt      = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_vld <= 1'b0;
      owner     <= 2'd0;
      last_ptr  <= 2'd3;
      hold      <= '0;
      q         <= '0;
      q_src     <= 2'd0;
      q_upd     <= 1'b0;
    end else begin
      owner_vld <= owner_vld_nxt;
      owner     <= owner_nxt;
      last_ptr  <= last_nxt;
      hold      <= hold_nxt;
      q_upd     <= owner_req;
      if (owner_req) begin
        q     <= wr_dat;
        q_src <= owner;
      end
    end
  end

  a_gnt_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
  a_write_src:  assert property (@(posedge clk) disable iff (rst)
                  q_upd |-> ($past(gnt) == (4'b0001 << q_src)) && (q == $past(wr_dat)));

endmodule

// File: tb/tb_rr_write_arbiter.sv
// Bench for rr_write_arbiter: directed scenarios plus random traffic, all checked
// against a cycle-level reference model of the ownership rules.
module tb_rr_write_arbiter;

  localparam int W  = 8;
  localparam int MH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    req;
  logic [4*W-1:0] data;
  logic [3:0]    gnt;
  logic [W-1:0]  q;
  logic [1:0]    q_src;
  logic          q_upd;

  int total = 0;
  int bad   = 0;

  // Reference model state: owner index or -1 when nobody holds the register.
  int       m_owner, m_last, m_hold, m_src;
  bit       m_upd;
  logic [7:0] m_q;
  int       wt [4];

  rr_write_arbiter #(.W(W), .MAX_HOLD(MH)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .data (data),
    .gnt  (gnt),
    .q    (q),
    .q_src(q_src),
    .q_upd(q_upd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int rr_pick(input int b, input logic [3:0] rq);
    for (int k = 1; k <= 4; k++)
      if (rq[(b + k) % 4]) return (b + k) % 4;
    return -1;
  endfunction

  task automatic m_step(input bit r, input logic [3:0] rq, input logic [31:0] d);
    int b;
    logic [3:0] oth;
    if (r) begin
      m_owner = -1; m_hold = 0; m_last = 3; m_q = 8'h00; m_src = 0; m_upd = 0;
      return;
    end
    if (m_owner >= 0 && rq[m_owner]) begin
      m_q   = d[m_owner*8 +: 8];
      m_src = m_owner;
      m_upd = 1;
    end else begin
      m_upd = 0;
    end
    b = (m_owner >= 0) ? m_owner : m_last;
    if (m_owner >= 0 && rq[m_owner]) begin
      oth = rq;
      oth[m_owner] = 1'b0;
      if (m_hold < MH || oth == 4'b0000) begin
        m_hold = (m_hold + 1 > MH) ? MH : m_hold + 1;
      end else begin
        m_owner = rr_pick(b, rq);
        m_hold  = 1;
        m_last  = m_owner;
      end
    end else if (rq != 4'b0000) begin
      m_owner = rr_pick(b, rq);
      m_hold  = 1;
      m_last  = m_owner;
    end else begin
      m_owner = -1;
      m_hold  = 0;
    end
  endtask

  // One clock cycle: drive inputs, advance the model, then compare after the edge.
  task automatic cyc(input bit r, input logic [3:0] rq, input logic [31:0] d);
    logic [3:0] eg;
    rst  = r;
    req  = rq;
    data = d;
    for (int i = 0; i < 4; i++) begin
      if (!r && rq[i] && !gnt[i]) wt[i]++;
      else wt[i] = 0;
      chk("fairness", 32'(wt[i] <= 3*MH + 1), 32'd1);
    end
    m_step(r, rq, d);
    @(posedge clk);
    @(negedge clk);
    eg = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    chk("gnt",   32'(gnt),   32'(eg));
    chk("q",     32'(q),     32'(m_q));
    chk("q_src", 32'(q_src), 32'(m_src));
    chk("q_upd", 32'(q_upd), 32'(m_upd));
  endtask

  initial begin
    logic [3:0]  rq;
    logic [31:0] d;
    bit          r;
    rst = 1'b1; req = 4'b0000; data = '0;
    m_owner = -1; m_hold = 0; m_last = 3; m_q = 8'h00; m_src = 0; m_upd = 0;
    for (int i = 0; i < 4; i++) wt[i] = 0;
    @(negedge clk);

    cyc(1, 4'b0000, 32'h0);
    cyc(1, 4'b0000, 32'h0);
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_q",   32'(q),   32'h0);

    // Single requester: grant one cycle later, write one cycle after that.
    cyc(0, 4'b0001, 32'h0000_00A5);
    chk("first_gnt", 32'(gnt), 32'h1);
    cyc(0, 4'b0001, 32'h0000_00A5);
    chk("first_q",     32'(q),     32'hA5);
    chk("first_q_src", 32'(q_src), 32'h0);
    chk("first_q_upd", 32'(q_upd), 32'h1);

    // Full contention rotates every MH cycles starting at index 0.
    cyc(1, 4'b0000, 32'h0);
    for (int k = 1; k <= 20; k++) begin
      cyc(0, 4'b1111, 32'h4433_2211);
      chk("rr_seq", 32'(gnt), 32'(4'b0001 << (((k - 1) / 4) % 4)));
      if (k > 1) chk("rr_q", 32'(q), 32'(8'h11 * (((k - 2) / 4) % 4 + 1)));
    end

    // Lone requester never rotates away.
    cyc(1, 4'b0000, 32'h0);
    for (int k = 1; k <= 10; k++) begin
      cyc(0, 4'b0100, 32'h00C3_0000 + 32'(k));
      chk("solo_gnt", 32'(gnt), 32'h4);
    end

    // Owner drops request mid-tenure: hand-off without a write from it.
    cyc(1, 4'b0000, 32'h0);
    cyc(0, 4'b0001, 32'h00C3_005A);
    cyc(0, 4'b0101, 32'h00C3_005A);
    cyc(0, 4'b0100, 32'h00C3_00FF);
    chk("drop_gnt",   32'(gnt),   32'h4);
    chk("drop_q_upd", 32'(q_upd), 32'h0);
    chk("drop_q",     32'(q),     32'h5A);

    // Reset in the middle of a grant.
    cyc(1, 4'b0000, 32'h0);
    cyc(0, 4'b0010, 32'h0000_7700);
    cyc(0, 4'b0010, 32'h0000_7700);
    chk("pre_rst_q", 32'(q), 32'h77);
    cyc(1, 4'b0010, 32'h0000_7700);
    chk("mid_rst_gnt",   32'(gnt),   32'h0);
    chk("mid_rst_q",     32'(q),     32'h0);
    chk("mid_rst_q_upd", 32'(q_upd), 32'h0);
    cyc(0, 4'b0011, 32'h0000_7766);
    chk("post_rst_gnt", 32'(gnt), 32'h1);

    // Random traffic with sticky requests and occasional reset.
    rq = 4'b0011;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 9) >= 7) rq = 4'($urandom);
      r = ($urandom_range(0, 199) == 0);
      d = $urandom;
      cyc(r, rq, d);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_write_arbiter.md
RR_WRITE_ARBITER -- requirements
Module: rr_write_arbiter

Interface
REQ-001 Parameter W, default 8: width of shared register and of each requester data slice.
REQ-002 Parameter MAX_HOLD, default 4: max consecutive grant cycles per requester under contention; legal range >= 1.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 req  input  4  per-requester write request; bit i = requester i.
REQ-006 data  input  4*W  write data; requester i slice = data[i*W +: W].
REQ-007 gnt  output  4  registered grant; one-hot or all-zero.
REQ-008 q  output  W  shared register contents.
REQ-009 q_src  output  2  index of requester that performed last write to q.
REQ-010 q_upd  output  1  one-cycle pulse: q was written at the preceding edge.

Function
REQ-011 gnt SHALL be one-hot or zero in every cycle; two writers never target q in the same cycle.
REQ-012 Internal state: owner (valid + 2-bit index), last pointer (2 bits), hold counter (saturating, 0..MAX_HOLD); gnt = one-hot decode of owner, zero when no owner.
REQ-013 Write: in a cycle with gnt[i]=1 and req[i]=1, the next edge SHALL load q <= data slice i, q_src <= i, q_upd <= 1; otherwise q and q_src hold, q_upd <= 0.
REQ-014 Grant latency: req[i] rising in cycle t with no owner and i winning arbitration -> gnt[i]=1 in cycle t+1; q updated in cycle t+2.
REQ-015 Round-robin pick: first index with req set, searching (ptr+1), (ptr+2), (ptr+3), ptr mod 4; ptr = current owner if valid, else last pointer.
REQ-016 Keep: owner valid, req[owner]=1, and (hold < MAX_HOLD or no other req bit set) -> owner unchanged, hold increments, saturating at MAX_HOLD.
REQ-017 Rotate on expiry: owner valid, req[owner]=1, hold = MAX_HOLD, some other req bit set -> new owner = RR pick, hold = 1.
REQ-018 Release: owner valid and req[owner]=0 -> new owner = RR pick over current req (owner excluded since not requesting); if req=0, owner invalid, hold = 0.
REQ-019 Idle: no owner and req!=0 -> owner = RR pick from last pointer, hold = 1; no owner and req=0 -> remain idle.
REQ-020 last pointer SHALL update to the index of every newly granted owner.
REQ-021 Ownership transfers edge-to-edge; no idle gap cycle inserted between owners.
REQ-022 Fairness: a requester holding req continuously SHALL receive gnt within 3*MAX_HOLD+1 cycles.
REQ-023 Requester dropping req in its granted cycle SHALL not write q in that cycle (REQ-013).
REQ-024 req/data changes while not granted have no effect on q.

Reset
REQ-025 rst sampled high SHALL set: gnt=0, owner invalid, hold=0, last pointer=3, q=0, q_src=0, q_upd=0.
REQ-026 rst overrides any write in the same cycle; reset mid-grant drops gnt next cycle with no write.
REQ-027 First arbitration after reset starts search at index 0 (pointer 3).

Verification (W=8, MAX_HOLD=4)
REQ-028 Reset, then req=0001, data slice0=0xA5 -> gnt=0001 next cycle; following cycle q=0xA5, q_src=0, q_upd=1.
REQ-029 req=1111 held 20 cycles -> gnt sequence 0001 x4, 0010 x4, 0100 x4, 1000 x4, 0001 x4; q tracks each owner's slice one cycle later.
REQ-030 req=0100 only, held 10 cycles -> gnt=0100 for all 10 granted cycles, no rotation, hold saturates at 4.
REQ-031 Owner 0 granted, req=0101, req[0] drops at hold=2 -> gnt=0100 next cycle; no write from requester 0 in drop cycle; q_upd=0 that edge.
REQ-032 rst high while gnt=0010 -> next cycle gnt=0000, q=0x00, q_upd=0; after release with req=0011 -> gnt=0001 first.
REQ-033 Assertions every cycle: gnt one-hot or zero; q_upd implies q equals past data slice at past q_src and past gnt[q_src]=1.
